// File: rtl/stream_source_if.sv
// Valid/ready stream bundle between the traffic generator and the stage under test.
interface stream_source_if #(
    parameter int D_WIDTH = 6
) ();
    logic               up_valid;
    logic               up_ready;
    logic [D_WIDTH-1:0] up_data;

    modport master (output up_valid, output up_data, input up_ready);
    modport slave  (input up_valid, input up_data, output up_ready);
endinterface

// File: rtl/stream_source.sv
// Programmable burst generator (incrementing or LFSR data, programmable gap) on a valid/ready stream.
// Optional STREAM_SOURCE_RAND_GAP_EN randomises each gap to a subset of the programmed length.
module stream_source #(
    parameter int                 D_WIDTH   = 6,
    parameter int                 CNT_WIDTH = 8,
    parameter int                 GAP_WIDTH = 4,
    parameter logic [D_WIDTH-1:0] LFSR_POLY = 6'h30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic [GAP_WIDTH-1:0] gap,
    input  logic [D_WIDTH-1:0]   seed,
    input  logic                 mode,
    stream_source_if.master      up,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sent_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 up_valid_q, up_valid_d;
    logic [D_WIDTH-1:0]   data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic                 mode_q, mode_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;

    logic                 handshake;
    logic [CNT_WIDTH-1:0] sent_inc;
    logic [D_WIDTH-1:0]   next_data;
    logic [GAP_WIDTH-1:0] gap_len;

`ifdef STREAM_SOURCE_RAND_GAP_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign gap_len = lfsr_q[GAP_WIDTH-1:0] & gap_q;
`else
    assign gap_len = gap_q;
`endif

    assign handshake = up_valid_q & up.up_ready;
    assign sent_inc  = sent_q + CNT_WIDTH'(1);
    assign next_data = mode_q ? ((data_q >> 1) ^ (data_q[0] ? LFSR_POLY : '0))
                              : data_q + D_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        sent_d    = sent_q;
        count_d   = count_q;
        gap_d     = gap_q;
        mode_d    = mode_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = count;
                    gap_d   = gap;
                    mode_d  = mode;
                    sent_d  = '0;
                    // An all-zero LFSR state would lock up, so substitute 1.
                    data_d  = (mode && seed == '0) ? D_WIDTH'(1) : seed;
                    state_d = (count == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    sent_d = sent_inc;
                    data_d = next_data;
                    if (sent_inc == count_q) begin
                        state_d = DONE;
                    end else if (gap_len == '0) begin
                        state_d = SEND;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        up_valid_d = (state_d == SEND);
        busy_d     = (state_d == SEND) || (state_d == GAP);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            up_valid_q <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sent_q     <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            mode_q     <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            up_valid_q <= up_valid_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sent_q     <= sent_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            mode_q     <= mode_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign up.up_valid = up_valid_q;
    assign up.up_data  = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sent_cnt    = sent_q;

endmodule
